// File: rtl/vslide_pkg.sv
// Shared types and sizing for the vSlide command sequencer.
package vslide_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 32;
   localparam int SEW_WIDTH  = 2;
   localparam int BE_WIDTH   = DATA_WIDTH / 8;
   localparam int VL_WIDTH   = 16;
   localparam int PIPE_LAT   = 6;
   localparam int CNT_WIDTH  = VL_WIDTH + 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [SEW_WIDTH-1:0] {
      SEW_8  = 2'd0,
      SEW_16 = 2'd1,
      SEW_32 = 2'd2,
      SEW_64 = 2'd3
   } sew_t;

   typedef struct packed {
      logic                  dir;
      logic                  insert;
      logic [SEW_WIDTH-1:0]  sew;
      logic [ADDR_WIDTH-1:0] src;
      logic [ADDR_WIDTH-1:0] dst;
      logic [DATA_WIDTH-1:0] scalar;
   } cmd_t;

endpackage

// File: rtl/vslide_if.sv
// Command, source-read and vSlide-feed signals of the slide sequencer.
interface vslide_if;
   import vslide_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_dir;
   logic                  req_insert;
   logic [SEW_WIDTH-1:0]  req_sew;
   logic [VL_WIDTH-1:0]   req_vl;
   logic [ADDR_WIDTH-1:0] req_src;
   logic [ADDR_WIDTH-1:0] req_dst;
   logic [DATA_WIDTH-1:0] req_scalar;

   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   logic                  slide_valid;
   logic [DATA_WIDTH-1:0] slide_vec0;
   logic [DATA_WIDTH-1:0] slide_vec1;
   logic [SEW_WIDTH-1:0]  slide_sew;
   logic                  slide_opsel;
   logic                  slide_insert;
   logic                  slide_start;
   logic                  slide_end;
   logic [ADDR_WIDTH-1:0] slide_addr;
   logic [BE_WIDTH-1:0]   slide_be;

   logic                  busy;
   logic                  done;

   modport slave (
      input  req_valid, req_dir, req_insert, req_sew, req_vl, req_src, req_dst, req_scalar,
      output req_ready,
      output rd_en, rd_addr,
      input  rd_data,
      output slide_valid, slide_vec0, slide_vec1, slide_sew, slide_opsel, slide_insert,
      output slide_start, slide_end, slide_addr, slide_be,
      output busy, done
   );

   modport master (
      output req_valid, req_dir, req_insert, req_sew, req_vl, req_src, req_dst, req_scalar,
      input  req_ready,
      input  rd_en, rd_addr,
      output rd_data,
      input  slide_valid, slide_vec0, slide_vec1, slide_sew, slide_opsel, slide_insert,
      input  slide_start, slide_end, slide_addr, slide_be,
      input  busy, done
   );

endinterface

// File: rtl/vslide_be_gen.sv
// Chunk count and final-chunk byte enables for a vl/sew pair.
module vslide_be_gen
   import vslide_pkg::*;
(
   input  logic [VL_WIDTH-1:0]  vl,
   input  logic [SEW_WIDTH-1:0] sew,
   output logic [CNT_WIDTH-1:0] nchunk,
   output logic [BE_WIDTH-1:0]  last_be
);

   logic [CNT_WIDTH-1:0] bytes;

   // CNT_WIDTH holds vl*8+7, so the rounding add cannot wrap.
   always_comb begin
      bytes  = CNT_WIDTH'(vl) << sew;
      nchunk = (bytes + CNT_WIDTH'(7)) >> 3;
      if (bytes[2:0] == 3'd0) begin
         last_be = '1;
      end else begin
         last_be = ~(8'hFF << bytes[2:0]);
      end
   end

endmodule

// File: rtl/vslide_seq.sv
// Slide command sequencer: reads source chunks, feeds vSlide with sideband, waits out its pipeline.
//   state | meaning
//   IDLE  | ready for a command
//   READ  | one source read per cycle, chunk k = 0..nchunk-1
//   DRAIN | last beat in flight through vSlide
//   DONE  | done pulse, back to IDLE next cycle
module vslide_seq
   import vslide_pkg::*;
#(
   parameter int PIPE_LAT_P = PIPE_LAT
) (
   input logic     clk,
   input logic     rst,
   vslide_if.slave bus
);

   state_t                state_q, state_d;
   cmd_t                  cmd_q;
   logic [CNT_WIDTH-1:0]  nchunk_w, nchunk_q, k_q;
   logic [BE_WIDTH-1:0]   last_be_w, last_be_q;
   logic [7:0]            drain_q;
   logic                  accept, last_k;
   logic                  rd_en, req_ready, busy, done;
   logic                  sv_q, start_q, end_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BE_WIDTH-1:0]   be_q;

   vslide_be_gen u_be_gen (
      .vl      (bus.req_vl),
      .sew     (bus.req_sew),
      .nchunk  (nchunk_w),
      .last_be (last_be_w)
   );

   assign accept = (state_q == IDLE) && bus.req_valid;
   assign last_k = (k_q == nchunk_q - CNT_WIDTH'(1));

   always_comb begin
      state_d   = state_q;
      rd_en     = 1'b0;
      req_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (bus.req_valid) begin
               state_d = (nchunk_w == '0) ? DONE : READ;
            end
         end
         READ: begin
            rd_en = 1'b1;
            if (last_k) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_q == 8'd0) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         nchunk_q  <= '0;
         last_be_q <= '0;
         k_q       <= '0;
         drain_q   <= '0;
         sv_q      <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cmd_q     <= '{dir: bus.req_dir, insert: bus.req_insert, sew: bus.req_sew,
                           src: bus.req_src, dst: bus.req_dst, scalar: bus.req_scalar};
            nchunk_q  <= nchunk_w;
            last_be_q <= last_be_w;
            k_q       <= '0;
         end else if (state_q == READ) begin
            k_q <= k_q + CNT_WIDTH'(1);
         end
         // DRAIN counts the remaining vSlide stages after the last beat is presented.
         if (state_q == READ && state_d == DRAIN) begin
            drain_q <= 8'(PIPE_LAT_P - 1);
         end else if (state_q == DRAIN) begin
            drain_q <= drain_q - 8'd1;
         end
         sv_q    <= rd_en;
         start_q <= rd_en && (k_q == '0);
         end_q   <= rd_en && last_k;
         addr_q  <= rd_en ? cmd_q.dst + ADDR_WIDTH'(k_q) : '0;
         be_q    <= rd_en ? (last_k ? last_be_q : '1) : '0;
      end
   end

   assign bus.req_ready    = req_ready;
   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.rd_en        = rd_en;
   assign bus.rd_addr      = rd_en ? cmd_q.src + ADDR_WIDTH'(k_q) : '0;
   assign bus.slide_valid  = sv_q;
   assign bus.slide_vec0   = sv_q ? bus.rd_data : '0;
   assign bus.slide_vec1   = cmd_q.scalar;
   assign bus.slide_sew    = cmd_q.sew;
   assign bus.slide_opsel  = cmd_q.dir;
   assign bus.slide_insert = cmd_q.insert;
   assign bus.slide_start  = start_q;
   assign bus.slide_end    = end_q;
   assign bus.slide_addr   = addr_q;
   assign bus.slide_be     = be_q;

endmodule

// File: tb/tb_vslide_seq.sv
// Directed and randomized checks of vslide_seq against a cycle-schedule model of slide commands.
module tb_vslide_seq;
   import vslide_pkg::*;

   typedef struct {
      logic        dir;
      logic        ins;
      logic [1:0]  sew;
      logic [15:0] vl;
      logic [31:0] src;
      logic [31:0] dst;
      logic [63:0] scalar;
   } tcmd_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vslide_if bus ();

   vslide_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, a};
   endfunction

   // Source memory with one cycle of read latency; junk when not reading.
   always @(posedge clk) begin
      bus.rd_data <= bus.rd_en ? mem_word(bus.rd_addr) : {$urandom(), $urandom()};
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input tcmd_t c);
      bus.req_dir    = c.dir;
      bus.req_insert = c.ins;
      bus.req_sew    = c.sew;
      bus.req_vl     = c.vl;
      bus.req_src    = c.src;
      bus.req_dst    = c.dst;
      bus.req_scalar = c.scalar;
   endtask

   // Model: chunk count, final byte enables and done cycle from plain arithmetic.
   task automatic model(input tcmd_t c, output int n, output logic [7:0] lbe, output int done_t);
      int bytes;
      int rem;
      bytes = int'(c.vl) * (1 << c.sew);
      n = (bytes + 7) / 8;
      rem = bytes - 8 * (n - 1);
      lbe = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      done_t = (n == 0) ? 1 : n + 1 + PIPE_LAT;
   endtask

   task automatic expect_cycle(input tcmd_t c, input int t, input int n, input logic [7:0] lbe,
                               input int done_t);
      string       tg;
      logic        rd_e, sv_e, busy_e;
      logic [31:0] ra_e, sa_e;
      logic [63:0] v0_e;
      logic [7:0]  be_e;
      int          k;
      tg     = $sformatf("t%0d", t);
      rd_e   = (t >= 1) && (t <= n);
      ra_e   = rd_e ? c.src + 32'(t - 1) : 32'h0;
      sv_e   = (t >= 2) && (t <= n + 1);
      k      = t - 2;
      sa_e   = sv_e ? c.dst + 32'(k) : 32'h0;
      be_e   = sv_e ? ((k == n - 1) ? lbe : 8'hFF) : 8'h00;
      v0_e   = sv_e ? mem_word(c.src + 32'(k)) : 64'h0;
      busy_e = (t >= 1) && (t <= done_t);
      check({tg, " rd_en"},     64'(bus.rd_en),       64'(rd_e));
      check({tg, " rd_addr"},   64'(bus.rd_addr),     64'(ra_e));
      check({tg, " s_valid"},   64'(bus.slide_valid), 64'(sv_e));
      check({tg, " s_start"},   64'(bus.slide_start), 64'(sv_e && k == 0));
      check({tg, " s_end"},     64'(bus.slide_end),   64'(sv_e && k == n - 1));
      check({tg, " s_addr"},    64'(bus.slide_addr),  64'(sa_e));
      check({tg, " s_be"},      64'(bus.slide_be),    64'(be_e));
      check({tg, " s_vec0"},    bus.slide_vec0,       v0_e);
      check({tg, " done"},      64'(bus.done),        64'(t == done_t));
      check({tg, " busy"},      64'(bus.busy),        64'(busy_e));
      check({tg, " req_ready"}, 64'(bus.req_ready),   64'(!busy_e));
      if (t >= 1) begin
         check({tg, " s_vec1"},   bus.slide_vec1,        c.scalar);
         check({tg, " s_sew"},    64'(bus.slide_sew),    64'(c.sew));
         check({tg, " s_opsel"},  64'(bus.slide_opsel),  64'(c.dir));
         check({tg, " s_insert"}, 64'(bus.slide_insert), 64'(c.ins));
      end
   endtask

   // Present c in the current (idle) cycle and follow it until the cycle after done.
   // With keep set, req_valid stays high and the fields switch to nxt while c is busy.
   task automatic run_cmd(input tcmd_t c, input bit keep, input tcmd_t nxt);
      int         n, done_t;
      logic [7:0] lbe;
      drive(c);
      bus.req_valid = 1'b1;
      check("t0 req_ready", 64'(bus.req_ready), 64'h1);
      model(c, n, lbe, done_t);
      for (int t = 1; t <= done_t + 1; t++) begin
         @(posedge clk);
         #1;
         if (t == 1) begin
            if (keep) drive(nxt);
            else bus.req_valid = 1'b0;
         end
         expect_cycle(c, t, n, lbe, done_t);
      end
   endtask

   task automatic check_reset_outputs(input string tg);
      check({tg, " rd_en"},     64'(bus.rd_en),        64'h0);
      check({tg, " rd_addr"},   64'(bus.rd_addr),      64'h0);
      check({tg, " s_valid"},   64'(bus.slide_valid),  64'h0);
      check({tg, " s_vec0"},    bus.slide_vec0,        64'h0);
      check({tg, " s_vec1"},    bus.slide_vec1,        64'h0);
      check({tg, " s_sew"},     64'(bus.slide_sew),    64'h0);
      check({tg, " s_opsel"},   64'(bus.slide_opsel),  64'h0);
      check({tg, " s_insert"},  64'(bus.slide_insert), 64'h0);
      check({tg, " s_start"},   64'(bus.slide_start),  64'h0);
      check({tg, " s_end"},     64'(bus.slide_end),    64'h0);
      check({tg, " s_addr"},    64'(bus.slide_addr),   64'h0);
      check({tg, " s_be"},      64'(bus.slide_be),     64'h0);
      check({tg, " busy"},      64'(bus.busy),         64'h0);
      check({tg, " done"},      64'(bus.done),         64'h0);
      check({tg, " req_ready"}, 64'(bus.req_ready),    64'h1);
   endtask

   function automatic tcmd_t mk(input logic dir, input logic ins, input logic [1:0] sew,
                                input logic [15:0] vl, input logic [31:0] src,
                                input logic [31:0] dst, input logic [63:0] scalar);
      tcmd_t c;
      c.dir = dir; c.ins = ins; c.sew = sew; c.vl = vl;
      c.src = src; c.dst = dst; c.scalar = scalar;
      return c;
   endfunction

   function automatic tcmd_t rand_cmd();
      return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                16'($urandom_range(0, 40)), $urandom(), $urandom(), {$urandom(), $urandom()});
   endfunction

   initial begin
      tcmd_t c, a, b;
      int    n, done_t;
      logic [7:0] lbe;

      rst = 1'b1;
      bus.req_valid = 1'b0;
      drive(mk(1'b0, 1'b0, 2'd0, 16'd0, 32'h0, 32'h0, 64'h0));
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single chunk: start and end together, full byte enables.
      c = mk(DIR_UP, 1'b0, 2'd0, 16'd8, 32'h10, 32'h40, 64'h1234_5678_9ABC_DEF0);
      run_cmd(c, 1'b0, c);
      // 20 bytes over three beats, final be 0x0F.
      c = mk(DIR_DOWN, 1'b0, 2'd2, 16'd5, 32'h100, 32'h200, 64'h77);
      run_cmd(c, 1'b0, c);
      // Empty command: immediate done, no reads.
      c = mk(DIR_UP, 1'b0, 2'd1, 16'd0, 32'h300, 32'h400, 64'h5);
      run_cmd(c, 1'b0, c);
      // Scalar carried on every beat.
      c = mk(DIR_UP, 1'b0, 2'd3, 16'd4, 32'h1000, 32'h2000, 64'hDEAD);
      run_cmd(c, 1'b0, c);
      // Addresses wrapping past the top of the address space, insert form.
      c = mk(DIR_DOWN, 1'b1, 2'd3, 16'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 64'hCAFE);
      run_cmd(c, 1'b0, c);

      // req_valid held high: second command waits for done, fields sampled at accept only.
      a = mk(DIR_UP, 1'b1, 2'd1, 16'd11, 32'h500, 32'h600, 64'hAAAA);
      b = mk(DIR_DOWN, 1'b0, 2'd2, 16'd3, 32'h700, 32'h800, 64'hBBBB);
      run_cmd(a, 1'b1, b);
      run_cmd(b, 1'b0, b);

      for (int i = 0; i < 16; i++) begin
         c = rand_cmd();
         run_cmd(c, 1'b0, c);
      end

      // Reset during an 8-chunk command, raised in cycle C+3.
      c = mk(DIR_UP, 1'b0, 2'd3, 16'd8, 32'h900, 32'hA00, 64'hF00D);
      model(c, n, lbe, done_t);
      drive(c);
      bus.req_valid = 1'b1;
      for (int t = 1; t <= 3; t++) begin
         @(posedge clk);
         #1;
         if (t == 1) bus.req_valid = 1'b0;
         expect_cycle(c, t, n, lbe, done_t);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_outputs("abort");
      for (int t = 0; t < 12; t++) begin
         @(posedge clk);
         #1;
         check($sformatf("post-abort%0d done", t), 64'(bus.done), 64'h0);
         check($sformatf("post-abort%0d s_valid", t), 64'(bus.slide_valid), 64'h0);
      end

      c = rand_cmd();
      run_cmd(c, 1'b0, c);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
